// File: rtl/fifo_hs_if.sv
// Handshake bundle for fifo_hs: producer request/acknowledge, consumer
// request/acknowledge, and the occupancy count.
interface fifo_hs_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] din;
  logic             rr;
  logic             ar;
  logic [WIDTH-1:0] dout;
  logic             rw;
  logic             aw;
  logic [LW-1:0]    level;

  // Environment side: drives the producer data/request and the consumer acknowledge.
  modport master (
    output din,
    output rr,
    output aw,
    input  ar,
    input  dout,
    input  rw,
    input  level
  );

  // FIFO side.
  modport slave (
    input  din,
    input  rr,
    input  aw,
    output ar,
    output dout,
    output rw,
    output level
  );
endinterface

// File: rtl/fifo_hs.sv
// Multi-entry FIFO with four-phase handshakes on both sides. The write and
// read FSMs are independent and share only the level count.
module fifo_hs #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  fifo_hs_if.slave   bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {
    W_IDLE = 1'b0,
    W_ACK  = 1'b1
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } rstate_e;

  wstate_e          wstate_q, wstate_d;
  rstate_e          rstate_q, rstate_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ar_q, ar_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             capture_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;

  // Pointers run over 0..DEPTH-1 so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full_s  = (level_q == LW'(DEPTH));
  assign empty_s = (level_q == {LW{1'b0}});

  // Write FSM: capture on rr with space, then hold ar until rr drops.
  always_comb begin
    wstate_d  = wstate_q;
    ar_d      = ar_q;
    wptr_d    = wptr_q;
    capture_s = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (bus.rr && !full_s) begin
          capture_s = 1'b1;
          wptr_d    = ptr_inc(wptr_q);
          ar_d      = 1'b1;
          wstate_d  = W_ACK;
        end else begin
          ar_d = 1'b0;
        end
      end
      W_ACK: begin
        if (!bus.rr) begin
          ar_d     = 1'b0;
          wstate_d = W_IDLE;
        end else begin
          ar_d = 1'b1;
        end
      end
      default: begin
        ar_d     = 1'b0;
        wstate_d = W_IDLE;
      end
    endcase
  end

  // Read FSM: offer the head entry, retire it on aw, then wait for aw to drop.
  always_comb begin
    rstate_d = rstate_q;
    rw_d     = rw_q;
    rptr_d   = rptr_q;
    dout_d   = dout_q;
    pop_s    = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (!empty_s) begin
          dout_d   = mem_q[rptr_q];
          rw_d     = 1'b1;
          rstate_d = R_REQ;
        end else begin
          rw_d = 1'b0;
        end
      end
      R_REQ: begin
        if (bus.aw) begin
          pop_s    = 1'b1;
          rw_d     = 1'b0;
          rptr_d   = ptr_inc(rptr_q);
          rstate_d = R_WAIT;
        end else begin
          rw_d = 1'b1;
        end
      end
      R_WAIT: begin
        rw_d = 1'b0;
        if (!bus.aw) begin
          rstate_d = R_IDLE;
        end else begin
          rstate_d = R_WAIT;
        end
      end
      default: begin
        rw_d     = 1'b0;
        rstate_d = R_IDLE;
      end
    endcase
  end

  // Occupancy: a simultaneous capture and pop leaves the count unchanged.
  always_comb begin
    level_d = level_q;
    case ({capture_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      wptr_q   <= {PW{1'b0}};
      rptr_q   <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
      ar_q     <= 1'b0;
      rw_q     <= 1'b0;
      dout_q   <= {WIDTH{1'b0}};
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      ar_q     <= ar_d;
      rw_q     <= rw_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array; contents become unreachable on reset because the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && capture_s) begin
      mem_q[wptr_q] <= bus.din;
    end
  end

  assign bus.ar    = ar_q;
  assign bus.rw    = rw_q;
  assign bus.dout  = dout_q;
  assign bus.level = level_q;
endmodule
